// File: rtl/row_merge_buffer_pkg.sv
// row_merge_buffer_pkg
//   Shared widths and types for the row merge buffer that sits behind the
//   post-hash reorder crossbar.
//   - ISSUE_W : lanes (byte positions) per window
//   - ADDR_W  : address width
//   - MML_W   : meta match length width
//   - CNT_W   : width of the saturating partial-flush counter
//   - lane_res_t : packed per-lane result {history_valid, history_addr,
//                  meta_match_len, can_ext}
//   - merge_state_e : EMPTY / ACCUM accumulator states
//   Optional feature macro used by the top: ROW_MERGE_SEQ_CHECK_EN

`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef META_MATCH_LEN_WIDTH
`define META_MATCH_LEN_WIDTH 5
`endif

package row_merge_buffer_pkg;

  localparam int ISSUE_W = `HASH_ISSUE_WIDTH;
  localparam int ADDR_W  = `ADDR_WIDTH;
  localparam int MML_W   = `META_MATCH_LEN_WIDTH;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic              history_valid;
    logic [ADDR_W-1:0] history_addr;
    logic [MML_W-1:0]  meta_match_len;
    logic              can_ext;
  } lane_res_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } merge_state_e;

endpackage

// File: rtl/row_merge_lane.sv
// row_merge_lane
//   One lane of the window accumulator. Holds the lane's result while a
//   window is being assembled from several beats, and offers the merged
//   value (new beat lane if present, else the held value) to the top.
//   Ports:
//   - clk, rst_n        : clock, async active-low reset
//   - beat_accept       : a beat is accepted this cycle
//   - beat_lane_valid   : the beat carries this lane
//   - beat_res          : the beat's result for this lane
//   - clear             : window leaves the accumulator this cycle
//   - acc_valid         : lane already filled in the accumulator
//   - acc_res           : held lane result (zero when not filled)
//   - merged_res        : beat value if carried, else held value
//   - overlap           : accepted beat re-delivers an already filled lane

module row_merge_lane
  import row_merge_buffer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      beat_accept,
  input  logic      beat_lane_valid,
  input  lane_res_t beat_res,
  input  logic      clear,
  output logic      acc_valid,
  output lane_res_t acc_res,
  output lane_res_t merged_res,
  output logic      overlap
);

  logic      acc_valid_q, acc_valid_d;
  lane_res_t acc_res_q, acc_res_d;

  // Cleared lanes are zeroed so an emitted window reports 0 in unfilled lanes.
  always_comb begin
    acc_valid_d = acc_valid_q;
    acc_res_d   = acc_res_q;
    merged_res  = beat_lane_valid ? beat_res : acc_res_q;
    overlap     = beat_accept && beat_lane_valid && acc_valid_q;
    if (clear) begin
      acc_valid_d = 1'b0;
      acc_res_d   = '0;
    end else if (beat_accept && beat_lane_valid) begin
      acc_valid_d = 1'b1;
      acc_res_d   = beat_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid_q <= 1'b0;
      acc_res_q   <= '0;
    end else begin
      acc_valid_q <= acc_valid_d;
      acc_res_q   <= acc_res_d;
    end
  end

  assign acc_valid = acc_valid_q;
  assign acc_res   = acc_res_q;

endmodule

// File: rtl/row_merge_buffer.sv
// row_merge_buffer
//   Merges partial crossbar beats sharing a window head address into one
//   complete window and emits it through a single-entry valid/ready output
//   register. Partial windows are flushed on a delimiter or when a beat with
//   a different head address arrives.
//   Inputs : clk, rst_n, input_valid, input_head_addr, input_row_valid,
//            input_history_valid, input_history_addr, input_meta_match_len,
//            input_meta_match_can_ext, input_data, input_delim, output_ready
//   Outputs: input_ready, output_valid and merged window payload,
//            stat_partial_flush_cnt, stat_overlap, stat_seq_err
//   Optional feature macro: ROW_MERGE_SEQ_CHECK_EN (head sequence check);
//   without it stat_seq_err is tied 0.

module row_merge_buffer
  import row_merge_buffer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     input_valid,
  input  logic [ADDR_W-1:0]        input_head_addr,
  input  logic [ISSUE_W-1:0]       input_row_valid,
  input  logic [ISSUE_W-1:0]       input_history_valid,
  input  logic [ISSUE_W*ADDR_W-1:0] input_history_addr,
  input  logic [ISSUE_W*MML_W-1:0] input_meta_match_len,
  input  logic [ISSUE_W-1:0]       input_meta_match_can_ext,
  input  logic [ISSUE_W*8-1:0]     input_data,
  input  logic                     input_delim,
  output logic                     input_ready,
  output logic                     output_valid,
  output logic [ADDR_W-1:0]        output_head_addr,
  output logic [ISSUE_W-1:0]       output_row_valid,
  output logic [ISSUE_W-1:0]       output_history_valid,
  output logic [ISSUE_W*ADDR_W-1:0] output_history_addr,
  output logic [ISSUE_W*MML_W-1:0] output_meta_match_len,
  output logic [ISSUE_W-1:0]       output_meta_match_can_ext,
  output logic [ISSUE_W*8-1:0]     output_data,
  output logic                     output_delim,
  input  logic                     output_ready,
  output logic [CNT_W-1:0]         stat_partial_flush_cnt,
  output logic                     stat_overlap,
  output logic                     stat_seq_err
);

  merge_state_e state_q, state_d;

  logic [ADDR_W-1:0]    acc_head_q, acc_head_d;
  logic [ISSUE_W*8-1:0] acc_data_q, acc_data_d;
  logic                 acc_delim_q, acc_delim_d;

  logic [ISSUE_W-1:0] acc_mask;
  logic [ISSUE_W-1:0] merged_mask;
  logic [ISSUE_W-1:0] overlap_vec;
  lane_res_t [ISSUE_W-1:0] beat_res;
  lane_res_t [ISSUE_W-1:0] acc_res;
  lane_res_t [ISSUE_W-1:0] merged_res;

  logic ld_ok, mismatch, flush, accept, emit, out_load, partial_evt;

  logic                      out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]         out_head_q, out_head_d;
  logic [ISSUE_W-1:0]        out_mask_q, out_mask_d;
  logic [ISSUE_W-1:0]        out_hv_q, out_hv_d;
  logic [ISSUE_W*ADDR_W-1:0] out_ha_q, out_ha_d;
  logic [ISSUE_W*MML_W-1:0]  out_mml_q, out_mml_d;
  logic [ISSUE_W-1:0]        out_ce_q, out_ce_d;
  logic [ISSUE_W*8-1:0]      out_data_q, out_data_d;
  logic                      out_delim_q, out_delim_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overlap_q, overlap_d;

  logic [ADDR_W-1:0] load_head;
  logic              load_delim;

  // Unpack the flat per-lane input buses into lane structs.
  always_comb begin
    beat_res = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      beat_res[i].history_valid  = input_history_valid[i];
      beat_res[i].history_addr   = input_history_addr[i*ADDR_W +: ADDR_W];
      beat_res[i].meta_match_len = input_meta_match_len[i*MML_W +: MML_W];
      beat_res[i].can_ext        = input_meta_match_can_ext[i];
    end
  end

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
    row_merge_lane u_lane (
      .clk             (clk),
      .rst_n           (rst_n),
      .beat_accept     (accept),
      .beat_lane_valid (input_row_valid[g]),
      .beat_res        (beat_res[g]),
      .clear           (out_load),
      .acc_valid       (acc_mask[g]),
      .acc_res         (acc_res[g]),
      .merged_res      (merged_res[g]),
      .overlap         (overlap_vec[g])
    );
  end

  // Handshake control. A head change while accumulating first pushes the
  // held partial window out; the new beat is taken on a later cycle.
  always_comb begin
    ld_ok       = !out_valid_q || output_ready;
    mismatch    = (state_q == ST_ACCUM) && input_valid && (input_head_addr != acc_head_q);
    flush       = mismatch && ld_ok;
    input_ready = rst_n && ld_ok && !mismatch;
    accept      = input_valid && input_ready;
    merged_mask = acc_mask | input_row_valid;
    emit        = accept && ((merged_mask == '1) || input_delim);
    out_load    = flush || emit;
    partial_evt = flush || (emit && (merged_mask != '1));
  end

  // Accumulator state and window-level fields.
  always_comb begin
    state_d     = state_q;
    acc_head_d  = acc_head_q;
    acc_data_d  = acc_data_q;
    acc_delim_d = acc_delim_q;
    if (out_load) begin
      state_d     = ST_EMPTY;
      acc_head_d  = '0;
      acc_data_d  = '0;
      acc_delim_d = 1'b0;
    end else if (accept) begin
      state_d     = (merged_mask != '0) ? ST_ACCUM : ST_EMPTY;
      acc_head_d  = input_head_addr;
      acc_data_d  = input_data;
      acc_delim_d = acc_delim_q | input_delim;
    end
  end

  // Output register: a flush loads the held window, an emit loads the
  // merged window; a handshake without a new load drops output_valid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_head_d  = out_head_q;
    out_mask_d  = out_mask_q;
    out_hv_d    = out_hv_q;
    out_ha_d    = out_ha_q;
    out_mml_d   = out_mml_q;
    out_ce_d    = out_ce_q;
    out_data_d  = out_data_q;
    out_delim_d = out_delim_q;
    load_head   = flush ? acc_head_q : input_head_addr;
    load_delim  = flush ? acc_delim_q : (acc_delim_q | input_delim);
    if (out_load) begin
      out_valid_d = 1'b1;
      out_head_d  = load_head;
      out_delim_d = load_delim;
      out_mask_d  = flush ? acc_mask : merged_mask;
      out_data_d  = flush ? acc_data_q : input_data;
      for (int i = 0; i < ISSUE_W; i++) begin
        out_hv_d[i]                  = flush ? acc_res[i].history_valid  : merged_res[i].history_valid;
        out_ha_d[i*ADDR_W +: ADDR_W] = flush ? acc_res[i].history_addr   : merged_res[i].history_addr;
        out_mml_d[i*MML_W +: MML_W]  = flush ? acc_res[i].meta_match_len : merged_res[i].meta_match_len;
        out_ce_d[i]                  = flush ? acc_res[i].can_ext        : merged_res[i].can_ext;
      end
    end else if (out_valid_q && output_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Statistics: saturating partial-window count and sticky overlap flag.
  always_comb begin
    cnt_d     = cnt_q;
    overlap_d = overlap_q | (|overlap_vec);
    if (partial_evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      acc_head_q  <= '0;
      acc_data_q  <= '0;
      acc_delim_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_head_q  <= '0;
      out_mask_q  <= '0;
      out_hv_q    <= '0;
      out_ha_q    <= '0;
      out_mml_q   <= '0;
      out_ce_q    <= '0;
      out_data_q  <= '0;
      out_delim_q <= 1'b0;
      cnt_q       <= '0;
      overlap_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_head_q  <= acc_head_d;
      acc_data_q  <= acc_data_d;
      acc_delim_q <= acc_delim_d;
      out_valid_q <= out_valid_d;
      out_head_q  <= out_head_d;
      out_mask_q  <= out_mask_d;
      out_hv_q    <= out_hv_d;
      out_ha_q    <= out_ha_d;
      out_mml_q   <= out_mml_d;
      out_ce_q    <= out_ce_d;
      out_data_q  <= out_data_d;
      out_delim_q <= out_delim_d;
      cnt_q       <= cnt_d;
      overlap_q   <= overlap_d;
    end
  end

`ifdef ROW_MERGE_SEQ_CHECK_EN
  // Consecutive windows inside a block must advance by one window; the
  // first window after a delimiter (or reset) starts a new block and is
  // not checked, hence prev_delim resets to 1.
  logic [ADDR_W-1:0] prev_head_q, prev_head_d;
  logic              prev_delim_q, prev_delim_d;
  logic              seq_err_q, seq_err_d;

  always_comb begin
    prev_head_d  = prev_head_q;
    prev_delim_d = prev_delim_q;
    seq_err_d    = seq_err_q;
    if (out_load) begin
      if (!prev_delim_q && (load_head != prev_head_q + ADDR_W'(ISSUE_W))) begin
        seq_err_d = 1'b1;
      end
      prev_head_d  = load_head;
      prev_delim_d = load_delim;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_head_q  <= '0;
      prev_delim_q <= 1'b1;
      seq_err_q    <= 1'b0;
    end else begin
      prev_head_q  <= prev_head_d;
      prev_delim_q <= prev_delim_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign stat_seq_err = seq_err_q;
`else
  assign stat_seq_err = 1'b0;
`endif

  assign output_valid              = out_valid_q;
  assign output_head_addr          = out_head_q;
  assign output_row_valid          = out_mask_q;
  assign output_history_valid      = out_hv_q;
  assign output_history_addr       = out_ha_q;
  assign output_meta_match_len     = out_mml_q;
  assign output_meta_match_can_ext = out_ce_q;
  assign output_data               = out_data_q;
  assign output_delim              = out_delim_q;
  assign stat_partial_flush_cnt    = cnt_q;
  assign stat_overlap              = overlap_q;

endmodule

// File: tb/tb_row_merge_buffer.sv
// tb_row_merge_buffer
//   Directed bench for row_merge_buffer: a table of single-cycle vectors
//   followed by hand-written sequences for lane merging, partial delimiter
//   windows, backpressure, overlap and the head sequence flag.

module tb_row_merge_buffer;
  import row_merge_buffer_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic                      input_valid;
  logic [ADDR_W-1:0]         input_head_addr;
  logic [ISSUE_W-1:0]        input_row_valid;
  logic [ISSUE_W-1:0]        input_history_valid;
  logic [ISSUE_W*ADDR_W-1:0] input_history_addr;
  logic [ISSUE_W*MML_W-1:0]  input_meta_match_len;
  logic [ISSUE_W-1:0]        input_meta_match_can_ext;
  logic [ISSUE_W*8-1:0]      input_data;
  logic                      input_delim;
  logic                      input_ready;
  logic                      output_valid;
  logic [ADDR_W-1:0]         output_head_addr;
  logic [ISSUE_W-1:0]        output_row_valid;
  logic [ISSUE_W-1:0]        output_history_valid;
  logic [ISSUE_W*ADDR_W-1:0] output_history_addr;
  logic [ISSUE_W*MML_W-1:0]  output_meta_match_len;
  logic [ISSUE_W-1:0]        output_meta_match_can_ext;
  logic [ISSUE_W*8-1:0]      output_data;
  logic                      output_delim;
  logic                      output_ready;
  logic [CNT_W-1:0]          stat_partial_flush_cnt;
  logic                      stat_overlap;
  logic                      stat_seq_err;

  int checks = 0;
  int errors = 0;

  row_merge_buffer dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .input_valid               (input_valid),
    .input_head_addr           (input_head_addr),
    .input_row_valid           (input_row_valid),
    .input_history_valid       (input_history_valid),
    .input_history_addr        (input_history_addr),
    .input_meta_match_len      (input_meta_match_len),
    .input_meta_match_can_ext  (input_meta_match_can_ext),
    .input_data                (input_data),
    .input_delim               (input_delim),
    .input_ready               (input_ready),
    .output_valid              (output_valid),
    .output_head_addr          (output_head_addr),
    .output_row_valid          (output_row_valid),
    .output_history_valid      (output_history_valid),
    .output_history_addr       (output_history_addr),
    .output_meta_match_len     (output_meta_match_len),
    .output_meta_match_can_ext (output_meta_match_can_ext),
    .output_data               (output_data),
    .output_delim              (output_delim),
    .output_ready              (output_ready),
    .stat_partial_flush_cnt    (stat_partial_flush_cnt),
    .stat_overlap              (stat_overlap),
    .stat_seq_err              (stat_seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic              valid;
    logic [ADDR_W-1:0] head;
    logic [15:0]       rv;
    logic              delim;
    logic [7:0]        tag;
    logic              exp_in_ready;
    logic              exp_out_valid;
    logic [ADDR_W-1:0] exp_head;
    logic [15:0]       exp_rv;
    logic              exp_delim;
    logic [15:0]       exp_partial;
  } vec_t;

  vec_t vecs [13];

  // Per-lane result of a beat is a fixed function of its tag and lane index.
  function automatic lane_res_t gen_lane(input logic [7:0] tag, input int lane);
    lane_res_t r;
    r.history_valid  = 1'b1;
    r.history_addr   = {8'hA5, tag, 8'h00, 8'(lane)};
    r.meta_match_len = MML_W'(tag + 8'(lane));
    r.can_ext        = tag[0] ^ lane[0];
    return r;
  endfunction

  task automatic applyStimulus(input logic valid, input logic [ADDR_W-1:0] head,
                               input logic [15:0] rv, input logic delim,
                               input logic [7:0] tag, input logic ready);
    lane_res_t r;
    input_valid     = valid;
    input_head_addr = head;
    input_row_valid = rv;
    input_delim     = delim;
    output_ready    = ready;
    input_data      = {ISSUE_W{tag}};
    for (int i = 0; i < ISSUE_W; i++) begin
      r = gen_lane(tag, i);
      input_history_valid[i]                 = r.history_valid;
      input_history_addr[i*ADDR_W +: ADDR_W] = r.history_addr;
      input_meta_match_len[i*MML_W +: MML_W] = r.meta_match_len;
      input_meta_match_can_ext[i]            = r.can_ext;
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // One clock: drive at the falling edge, check input_ready before the
  // rising edge, then leave the registered outputs to settle for 1ns.
  task automatic cycle(input logic valid, input logic [ADDR_W-1:0] head,
                       input logic [15:0] rv, input logic delim,
                       input logic [7:0] tag, input logic ready,
                       input logic exp_in_ready, input string name);
    @(negedge clk);
    applyStimulus(valid, head, rv, delim, tag, ready);
    #1;
    checkOutput({name, ".in_ready"}, 128'(input_ready), 128'(exp_in_ready));
    @(posedge clk);
    #1;
  endtask

  lane_res_t exp_r;

  initial begin
    // Table: each entry is one cycle with output_ready=1.
    vecs[0]  = '{1'b1, 32'h40, 16'hFFFF, 1'b0, 8'd1, 1'b1, 1'b1, 32'h40, 16'hFFFF, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 32'h0,  16'h0000, 1'b0, 8'd0, 1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 32'h50, 16'h00FF, 1'b0, 8'd2, 1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 32'h50, 16'hFF00, 1'b0, 8'd3, 1'b1, 1'b1, 32'h50, 16'hFFFF, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 32'h60, 16'h000F, 1'b0, 8'd4, 1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 32'h70, 16'hFFFF, 1'b0, 8'd5, 1'b0, 1'b1, 32'h60, 16'h000F, 1'b0, 16'd1};
    vecs[6]  = '{1'b1, 32'h70, 16'hFFFF, 1'b0, 8'd5, 1'b1, 1'b1, 32'h70, 16'hFFFF, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 32'h80, 16'h0003, 1'b1, 8'd6, 1'b1, 1'b1, 32'h80, 16'h0003, 1'b1, 16'd2};
    vecs[8]  = '{1'b1, 32'h90, 16'h0000, 1'b0, 8'd7, 1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 16'd2};
    vecs[9]  = '{1'b1, 32'hA0, 16'h0000, 1'b1, 8'd8, 1'b1, 1'b1, 32'hA0, 16'h0000, 1'b1, 16'd3};
    vecs[10] = '{1'b1, 32'hB0, 16'hFFFF, 1'b0, 8'd9, 1'b1, 1'b1, 32'hB0, 16'hFFFF, 1'b0, 16'd3};
    vecs[11] = '{1'b1, 32'hC0, 16'hFFFF, 1'b0, 8'd10, 1'b1, 1'b1, 32'hC0, 16'hFFFF, 1'b0, 16'd3};
    vecs[12] = '{1'b0, 32'h0,  16'h0000, 1'b0, 8'd0, 1'b1, 1'b0, 32'h0,  16'h0000, 1'b0, 16'd3};

    // Reset state.
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 8'd0, 1'b1);
    #12;
    checkOutput("reset.in_ready", 128'(input_ready), 128'(1'b0));
    checkOutput("reset.out_valid", 128'(output_valid), 128'(1'b0));
    checkOutput("reset.out_head", 128'(output_head_addr), 128'(0));
    checkOutput("reset.out_data", 128'(output_data), 128'(0));
    checkOutput("reset.partial_cnt", 128'(stat_partial_flush_cnt), 128'(0));
    checkOutput("reset.overlap", 128'(stat_overlap), 128'(1'b0));
    checkOutput("reset.seq_err", 128'(stat_seq_err), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle vectors.
    for (int v = 0; v < 13; v++) begin
      cycle(vecs[v].valid, vecs[v].head, vecs[v].rv, vecs[v].delim, vecs[v].tag,
            1'b1, vecs[v].exp_in_ready, $sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d.out_valid", v), 128'(output_valid), 128'(vecs[v].exp_out_valid));
      if (vecs[v].exp_out_valid) begin
        checkOutput($sformatf("vec%0d.out_head", v), 128'(output_head_addr), 128'(vecs[v].exp_head));
        checkOutput($sformatf("vec%0d.out_row_valid", v), 128'(output_row_valid), 128'(vecs[v].exp_rv));
        checkOutput($sformatf("vec%0d.out_delim", v), 128'(output_delim), 128'(vecs[v].exp_delim));
      end
      checkOutput($sformatf("vec%0d.partial_cnt", v), 128'(stat_partial_flush_cnt), 128'(vecs[v].exp_partial));
    end

    // Two-beat merge: lanes come from their own beats.
    cycle(1'b1, 32'hD0, 16'h00FF, 1'b0, 8'd9, 1'b1, 1'b1, "merge.b0");
    checkOutput("merge.b0.out_valid", 128'(output_valid), 128'(1'b0));
    cycle(1'b1, 32'hD0, 16'hFF00, 1'b0, 8'd10, 1'b1, 1'b1, "merge.b1");
    checkOutput("merge.out_valid", 128'(output_valid), 128'(1'b1));
    checkOutput("merge.out_row_valid", 128'(output_row_valid), 128'(16'hFFFF));
    checkOutput("merge.hist_valid", 128'(output_history_valid), 128'(16'hFFFF));
    checkOutput("merge.can_ext", 128'(output_meta_match_can_ext), 128'(16'hAA55));
    exp_r = gen_lane(8'd9, 3);
    checkOutput("merge.lane3_addr", 128'(output_history_addr[3*ADDR_W +: ADDR_W]), 128'(exp_r.history_addr));
    checkOutput("merge.lane3_len", 128'(output_meta_match_len[3*MML_W +: MML_W]), 128'(exp_r.meta_match_len));
    exp_r = gen_lane(8'd10, 12);
    checkOutput("merge.lane12_addr", 128'(output_history_addr[12*ADDR_W +: ADDR_W]), 128'(exp_r.history_addr));
    checkOutput("merge.data", 128'(output_data), {16{8'h0A}});

    // Delimited partial window: unfilled lanes are zero.
    cycle(1'b1, 32'hE0, 16'h0003, 1'b1, 8'd11, 1'b1, 1'b1, "delim");
    checkOutput("delim.out_valid", 128'(output_valid), 128'(1'b1));
    checkOutput("delim.out_delim", 128'(output_delim), 128'(1'b1));
    checkOutput("delim.hist_valid", 128'(output_history_valid), 128'(16'h0003));
    checkOutput("delim.can_ext", 128'(output_meta_match_can_ext), 128'(16'h0001));
    exp_r = gen_lane(8'd11, 1);
    checkOutput("delim.lane1_addr", 128'(output_history_addr[1*ADDR_W +: ADDR_W]), 128'(exp_r.history_addr));
    checkOutput("delim.lane5_addr", 128'(output_history_addr[5*ADDR_W +: ADDR_W]), 128'(0));
    checkOutput("delim.lane5_len", 128'(output_meta_match_len[5*MML_W +: MML_W]), 128'(0));
    checkOutput("delim.partial_cnt", 128'(stat_partial_flush_cnt), 128'(4));

    // Backpressure: output_ready low for 5 cycles while 3 windows are offered.
    cycle(1'b0, '0, '0, 1'b0, 8'd0, 1'b1, 1'b1, "bp.drain");
    checkOutput("bp.drain.out_valid", 128'(output_valid), 128'(1'b0));
    cycle(1'b1, 32'h100, 16'hFFFF, 1'b0, 8'd20, 1'b0, 1'b1, "bp.w0");
    checkOutput("bp.w0.out_head", 128'(output_head_addr), 128'(32'h100));
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 32'h110, 16'hFFFF, 1'b0, 8'd21, 1'b0, 1'b0, $sformatf("bp.stall%0d", c));
      checkOutput($sformatf("bp.stall%0d.out_valid", c), 128'(output_valid), 128'(1'b1));
      checkOutput($sformatf("bp.stall%0d.out_head", c), 128'(output_head_addr), 128'(32'h100));
      checkOutput($sformatf("bp.stall%0d.out_data", c), 128'(output_data), {16{8'd20}});
    end
    cycle(1'b1, 32'h110, 16'hFFFF, 1'b0, 8'd21, 1'b1, 1'b1, "bp.w1");
    checkOutput("bp.w1.out_head", 128'(output_head_addr), 128'(32'h110));
    cycle(1'b1, 32'h120, 16'hFFFF, 1'b0, 8'd22, 1'b1, 1'b1, "bp.w2");
    checkOutput("bp.w2.out_valid", 128'(output_valid), 128'(1'b1));
    checkOutput("bp.w2.out_head", 128'(output_head_addr), 128'(32'h120));
    cycle(1'b0, '0, '0, 1'b0, 8'd0, 1'b1, 1'b1, "bp.idle");
    checkOutput("bp.idle.out_valid", 128'(output_valid), 128'(1'b0));
    checkOutput("bp.seq_err", 128'(stat_seq_err), 128'(1'b0));

    // Overlap on lane 0: the later value wins. Head 0x200 also breaks the
    // window sequence after 0x120.
    cycle(1'b1, 32'h200, 16'h0001, 1'b0, 8'd30, 1'b1, 1'b1, "ovl.b0");
    checkOutput("ovl.b0.overlap", 128'(stat_overlap), 128'(1'b0));
    cycle(1'b1, 32'h200, 16'h0001, 1'b0, 8'd31, 1'b1, 1'b1, "ovl.b1");
    checkOutput("ovl.b1.overlap", 128'(stat_overlap), 128'(1'b1));
    checkOutput("ovl.b1.out_valid", 128'(output_valid), 128'(1'b0));
    cycle(1'b1, 32'h200, 16'hFFFE, 1'b0, 8'd32, 1'b1, 1'b1, "ovl.b2");
    checkOutput("ovl.out_valid", 128'(output_valid), 128'(1'b1));
    checkOutput("ovl.out_row_valid", 128'(output_row_valid), 128'(16'hFFFF));
    exp_r = gen_lane(8'd31, 0);
    checkOutput("ovl.lane0_addr", 128'(output_history_addr[0 +: ADDR_W]), 128'(exp_r.history_addr));
    exp_r = gen_lane(8'd32, 1);
    checkOutput("ovl.lane1_addr", 128'(output_history_addr[1*ADDR_W +: ADDR_W]), 128'(exp_r.history_addr));
    checkOutput("ovl.partial_cnt", 128'(stat_partial_flush_cnt), 128'(4));
`ifdef ROW_MERGE_SEQ_CHECK_EN
    checkOutput("ovl.seq_err", 128'(stat_seq_err), 128'(1'b1));
`else
    checkOutput("ovl.seq_err", 128'(stat_seq_err), 128'(1'b0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_merge_buffer.md
Name: row_merge_buffer

Overview:
- Sits directly downstream of the post-hash reorder crossbar in the post_hash_pe_scheduler.
- The crossbar emits one beat per accepted PE group. A beat carries a window head address plus per-lane results; one window may be split over several consecutive beats with the same head address.
- This block merges those partial beats into one complete window per head address and emits it through a single-entry output register with valid/ready.
- It flushes partial windows on a delimiter or a head-address change, and keeps statistics.

Parameters:
- ISSUE_W, `HASH_ISSUE_WIDTH (16): lanes (byte positions) per window.
- ADDR_W, `ADDR_WIDTH (32): address width.
- MML_W, `META_MATCH_LEN_WIDTH (5): meta match length width.
- CNT_W, 16: width of the saturating partial-flush counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- input_valid  in  1  beat valid.
- input_head_addr  in  ADDR_W  window head address; low log2(ISSUE_W) bits are zero.
- input_row_valid  in  ISSUE_W  lanes carried by this beat.
- input_history_valid  in  ISSUE_W  per-lane history hit.
- input_history_addr  in  ISSUE_W*ADDR_W  per-lane history address.
- input_meta_match_len  in  ISSUE_W*MML_W  per-lane meta match length.
- input_meta_match_can_ext  in  ISSUE_W  per-lane can-extend flag.
- input_data  in  ISSUE_W*8  window bytes.
- input_delim  in  1  last beat of a block.
- input_ready  out  1  beat accepted when high together with input_valid.
- output_valid  out  1  merged window valid.
- output_head_addr, output_row_valid, output_history_valid, output_history_addr, output_meta_match_len, output_meta_match_can_ext, output_data, output_delim  out  same widths as the inputs  merged window.
- output_ready  in  1  downstream accept.
- stat_partial_flush_cnt  out  CNT_W  saturating count of windows emitted with row_valid not all-ones.
- stat_overlap  out  1  sticky: a beat re-delivered an already-filled lane.
- stat_seq_err  out  1  sticky sequence error (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - output_valid=0, all output payloads 0.
  - Accumulator empty (acc_mask=0), stat counters and flags 0.
  - input_ready=0 while in reset.
- Accumulator state: acc_mask[ISSUE_W], acc_head, acc_delim, per-lane fields, acc_data.
- Two states:
  - EMPTY: acc_mask==0.
  - ACCUM: acc_mask!=0.
- Output register: loadable ("ld_ok") when !output_valid || output_ready. On a handshake with no new load, output_valid clears.
- Mismatch condition: ACCUM && input_valid && input_head_addr!=acc_head.
  - input_ready=0.
  - If ld_ok: the accumulator is moved to the output as a partial window, acc_mask is cleared, and stat_partial_flush_cnt increments (saturating).
  - The same beat is accepted in a later cycle.
- Otherwise input_ready=ld_ok. On an accepted beat:
  - merged_mask = acc_mask | input_row_valid.
  - Lanes set in input_row_valid take the new field values; other lanes keep the accumulator values.
  - acc_head and acc_data load from the beat.
  - acc_delim = acc_delim | input_delim.
- Overlap: if (acc_mask & input_row_valid)!=0, stat_overlap is set and the newer lane value wins.
- Emit condition: merged_mask all-ones, or input_delim=1.
  - The merged window loads the output register in the same cycle; output_valid rises on the next cycle (latency 1).
  - Accumulator returns to EMPTY.
  - If merged_mask is not all-ones, stat_partial_flush_cnt increments.
  - Otherwise the accumulator is updated and the state becomes ACCUM.
- Unfilled lanes in an emitted window: output_row_valid=0, history_valid=0, can_ext=0, len=0, addr=0.
- A beat with input_row_valid==0 and no delim only updates head/data; it never emits.
- A beat with input_row_valid==0 and delim emits a window with output_row_valid=0 and output_delim=1.
- Throughput: one complete single-beat window per cycle under continuous output_ready=1.
- Backpressure: output_ready=0 stalls input_ready. Payload is held stable while output_valid && !output_ready.

Optional Feature:
- Macro: ROW_MERGE_SEQ_CHECK_EN.
- Defined:
  - On each output load, if the previous emitted window had delim=0 and the new head != prev_head+ISSUE_W, stat_seq_err is set (sticky).
  - A `LOG message is printed with both addresses.
  - After a delim window, the next head address is unchecked.
- Undefined: stat_seq_err is tied 0 and no tracking register exists.

Decomposition:
- Shared package/header (parameters.vh): lane-count and width macros, and a packed per-lane result struct {history_valid, history_addr, meta_match_len, can_ext}.
- Sub-module row_merge_lane, instantiated ISSUE_W times: per-lane accumulator register with merge/clear controls and an overlap flag.
- Control FSM and output register stay in the top module.

Test Plan:
- Single beat head=0x40, row_valid=0xFFFF -> output_valid one cycle later, head 0x40, row_valid 0xFFFF, partial_cnt 0.
- Two beats head=0x50 with row_valid 0x00FF then 0xFF00 -> one output, row_valid 0xFFFF, lane fields from their respective beats.
- Beat head=0x60 row_valid 0x000F, then head=0x70 row_valid 0xFFFF:
  - input_ready=0 for one cycle.
  - Outputs 0x60 (row_valid 0x000F) then 0x70.
  - partial_cnt=1.
- Beat head=0x80 row_valid 0x0003 with delim=1 -> immediate partial output with output_delim=1; lanes 2..15 have history_valid=0.
- output_ready held 0 for 5 cycles while 3 windows are offered -> one output held stable, input_ready=0; after release, 3 windows emerge in order with no loss.
- Overlapping beats on lane 0 -> stat_overlap=1 and the second value is output. With ROW_MERGE_SEQ_CHECK_EN, heads 0x00 then 0x20 -> stat_seq_err=1.
